// File: rtl/tilelink_ul_sram_responder.sv
// TileLink-UL responder backed by a byte-maskable word memory.
// Handles Get/PutFullData/PutPartialData with one outstanding request, one per cycle when D is not stalled.
module tilelink_ul_sram_responder #(
  parameter int              AW      = 32,
  parameter int              DW      = 32,
  parameter int              RS      = 4,
  parameter logic [AW-1:0]   BASE    = '0,
  parameter int              LGDEPTH = 10
) (
  input  logic              tilelink_clock,
  input  logic              tilelink_reset,
  input  logic [2:0]        a_opcode,
  input  logic [2:0]        a_param,
  input  logic [3:0]        a_size,
  input  logic [RS-1:0]     a_source,
  input  logic [AW-1:0]     a_address,
  input  logic [DW/8-1:0]   a_mask,
  input  logic [DW-1:0]     a_data,
  input  logic              a_corrupt,
  input  logic              a_valid,
  output logic              a_ready,
  output logic [2:0]        d_opcode,
  output logic [1:0]        d_param,
  output logic [3:0]        d_size,
  output logic [RS-1:0]     d_source,
  output logic              d_denied,
  output logic [DW-1:0]     d_data,
  output logic              d_corrupt,
  output logic              d_valid,
  input  logic              d_ready
);

  localparam int         NB    = DW / 8;
  localparam int         LGB   = $clog2(NB);
  localparam int         MEMB  = LGDEPTH + LGB;
  localparam int         DEPTH = 1 << LGDEPTH;
  localparam logic [3:0] LGB4  = 4'(LGB);

  logic [DW-1:0]      mem [DEPTH];
  logic [AW-1:0]      offset;
  logic [LGDEPTH-1:0] idx;
  logic               a_fire;
  logic               op_get;
  logic               op_put;
  logic               in_range;
  logic               aligned;
  logic               size_ok;
  logic               denied;
  logic               wr_en;
  logic               rd_en;
  logic               unused_ok;

  assign unused_ok = ^{a_param, 1'b0};

  assign a_ready = !d_valid || d_ready;
  assign a_fire  = a_valid && a_ready;

  // Offset wraps for addresses below BASE, so one unsigned check covers both ends of the window.
  assign offset   = a_address - BASE;
  assign in_range = ((offset >> MEMB) == '0);
  assign aligned  = ((a_address & ~({AW{1'b1}} << a_size)) == '0);
  assign size_ok  = (a_size <= LGB4);
  assign idx      = LGDEPTH'(offset >> LGB);

  assign op_get = (a_opcode == 3'd4);
  assign op_put = (a_opcode == 3'd0) || (a_opcode == 3'd1);
  assign denied = !(op_get || op_put) || !size_ok || !aligned || !in_range;

  assign wr_en = a_fire && op_put && !denied && !a_corrupt;
  assign rd_en = a_fire && op_get && !denied;

  always_ff @(posedge tilelink_clock) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (a_mask[i]) mem[idx][8*i +: 8] <= a_data[8*i +: 8];
      end
    end
  end

  assign d_param = 2'b00;

  always_ff @(posedge tilelink_clock or negedge tilelink_reset) begin
    if (!tilelink_reset) begin
      d_valid   <= 1'b0;
      d_opcode  <= 3'd0;
      d_size    <= 4'd0;
      d_source  <= '0;
      d_denied  <= 1'b0;
      d_corrupt <= 1'b0;
      d_data    <= '0;
    end else if (a_fire) begin
      d_valid   <= 1'b1;
      d_opcode  <= op_get ? 3'd1 : 3'd0;
      d_size    <= a_size;
      d_source  <= a_source;
      d_denied  <= denied;
      d_corrupt <= op_get && denied;
      d_data    <= rd_en ? mem[idx] : '0;
    end else if (d_ready) begin
      d_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tilelink_ul_sram_responder.sv
// Directed bench for tilelink_ul_sram_responder with hand-computed expectations.
module tb_tilelink_ul_sram_responder;

  localparam logic [31:0] BASE = 32'h0000_2000;

  logic        tilelink_clock = 1'b0;
  logic        tilelink_reset = 1'b0;
  logic [2:0]  a_opcode = '0;
  logic [2:0]  a_param = '0;
  logic [3:0]  a_size = '0;
  logic [3:0]  a_source = '0;
  logic [31:0] a_address = '0;
  logic [3:0]  a_mask = '0;
  logic [31:0] a_data = '0;
  logic        a_corrupt = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic [3:0]  d_source;
  logic        d_denied;
  logic [31:0] d_data;
  logic        d_corrupt;
  logic        d_valid;
  logic        d_ready = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  tilelink_ul_sram_responder #(
    .AW(32), .DW(32), .RS(4), .BASE(BASE), .LGDEPTH(10)
  ) dut (
    .tilelink_clock(tilelink_clock), .tilelink_reset(tilelink_reset),
    .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .a_corrupt(a_corrupt),
    .a_valid(a_valid), .a_ready(a_ready),
    .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_source(d_source),
    .d_denied(d_denied), .d_data(d_data), .d_corrupt(d_corrupt),
    .d_valid(d_valid), .d_ready(d_ready)
  );

  always #5 tilelink_clock = ~tilelink_clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one A beat for a single edge; returns 1 time unit after that edge.
  task automatic req(input logic [2:0] op, input logic [3:0] sz, input logic [3:0] src,
                     input logic [31:0] addr, input logic [3:0] msk, input logic [31:0] dat,
                     input logic cor);
    a_opcode  = op;
    a_size    = sz;
    a_source  = src;
    a_address = addr;
    a_mask    = msk;
    a_data    = dat;
    a_corrupt = cor;
    a_valid   = 1'b1;
    @(posedge tilelink_clock);
    #1;
    a_valid   = 1'b0;
    a_corrupt = 1'b0;
  endtask

  task automatic expect_d(input string tag, input logic [2:0] op, input logic [3:0] src,
                          input logic [3:0] sz, input logic den, input logic cor,
                          input logic [31:0] dat);
    chk({tag, ".valid"}, 64'(d_valid), 64'(1));
    chk({tag, ".op"}, 64'(d_opcode), 64'(op));
    chk({tag, ".src"}, 64'(d_source), 64'(src));
    chk({tag, ".size"}, 64'(d_size), 64'(sz));
    chk({tag, ".denied"}, 64'(d_denied), 64'(den));
    chk({tag, ".corrupt"}, 64'(d_corrupt), 64'(cor));
    chk({tag, ".param"}, 64'(d_param), 64'(0));
    if (op == 3'd1) chk({tag, ".data"}, 64'(d_data), 64'(dat));
  endtask

  task automatic idle_cycle();
    a_valid = 1'b0;
    @(posedge tilelink_clock);
    #1;
  endtask

  initial begin
    logic [3:0]  qsrc [$];
    logic [31:0] qdat [$];
    logic        pat [4];
    int          issued;
    int          got;
    logic        exp_rdy;
    logic        fire_a;
    logic        fire_d;

    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    repeat (3) @(posedge tilelink_clock);
    #1;
    chk("rst.valid", 64'(d_valid), 64'(0));
    chk("rst.op", 64'(d_opcode), 64'(0));
    chk("rst.data", 64'(d_data), 64'(0));
    chk("rst.src", 64'(d_source), 64'(0));
    chk("rst.denied", 64'(d_denied), 64'(0));
    chk("rst.corrupt", 64'(d_corrupt), 64'(0));
    tilelink_reset = 1'b1;
    #1;
    chk("rst.aready", 64'(a_ready), 64'(1));
    @(posedge tilelink_clock);
    #1;

    req(3'd0, 4'd2, 4'd3, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0);
    expect_d("put1", 3'd0, 4'd3, 4'd2, 1'b0, 1'b0, 32'h0);
    req(3'd4, 4'd2, 4'd5, BASE + 32'h10, 4'hF, 32'h0, 1'b0);
    expect_d("get1", 3'd1, 4'd5, 4'd2, 1'b0, 1'b0, 32'hDEAD_BEEF);

    req(3'd1, 4'd2, 4'd1, BASE + 32'h10, 4'b0101, 32'h1122_3344, 1'b0);
    expect_d("pputp", 3'd0, 4'd1, 4'd2, 1'b0, 1'b0, 32'h0);
    req(3'd4, 4'd2, 4'd2, BASE + 32'h10, 4'hF, 32'h0, 1'b0);
    expect_d("pget", 3'd1, 4'd2, 4'd2, 1'b0, 1'b0, 32'hDE22_BE44);

    req(3'd4, 4'd2, 4'd6, BASE + 32'h1000, 4'hF, 32'h0, 1'b0);
    expect_d("oor_hi", 3'd1, 4'd6, 4'd2, 1'b1, 1'b1, 32'h0);
    req(3'd4, 4'd2, 4'd7, BASE - 32'h4, 4'hF, 32'h0, 1'b0);
    expect_d("oor_lo", 3'd1, 4'd7, 4'd2, 1'b1, 1'b1, 32'h0);
    req(3'd4, 4'd3, 4'd8, BASE + 32'h10, 4'hF, 32'h0, 1'b0);
    expect_d("size3", 3'd1, 4'd8, 4'd3, 1'b1, 1'b1, 32'h0);
    req(3'd0, 4'd2, 4'd9, BASE + 32'h12, 4'hF, 32'h0, 1'b0);
    expect_d("misal", 3'd0, 4'd9, 4'd2, 1'b1, 1'b0, 32'h0);
    req(3'd4, 4'd2, 4'd10, BASE + 32'h10, 4'hF, 32'h0, 1'b0);
    expect_d("misal_get", 3'd1, 4'd10, 4'd2, 1'b0, 1'b0, 32'hDE22_BE44);
    req(3'd6, 4'd2, 4'd11, BASE + 32'h10, 4'hF, 32'h0, 1'b0);
    expect_d("op6", 3'd0, 4'd11, 4'd2, 1'b1, 1'b0, 32'h0);

    req(3'd1, 4'd1, 4'd12, BASE + 32'h12, 4'b1100, 32'hAAAA_0000, 1'b0);
    expect_d("half", 3'd0, 4'd12, 4'd1, 1'b0, 1'b0, 32'h0);
    req(3'd4, 4'd2, 4'd13, BASE + 32'h10, 4'hF, 32'h0, 1'b0);
    expect_d("half_get", 3'd1, 4'd13, 4'd2, 1'b0, 1'b0, 32'hAAAA_BE44);

    req(3'd0, 4'd2, 4'd1, BASE + 32'h20, 4'hF, 32'hCAFE_F00D, 1'b0);
    expect_d("cput0", 3'd0, 4'd1, 4'd2, 1'b0, 1'b0, 32'h0);
    req(3'd0, 4'd2, 4'd2, BASE + 32'h20, 4'hF, 32'h0, 1'b1);
    expect_d("cput1", 3'd0, 4'd2, 4'd2, 1'b0, 1'b0, 32'h0);
    req(3'd4, 4'd2, 4'd3, BASE + 32'h20, 4'hF, 32'h0, 1'b0);
    expect_d("cget", 3'd1, 4'd3, 4'd2, 1'b0, 1'b0, 32'hCAFE_F00D);

    req(3'd0, 4'd2, 4'd4, BASE + 32'hFFC, 4'hF, 32'h1234_5678, 1'b0);
    expect_d("last_put", 3'd0, 4'd4, 4'd2, 1'b0, 1'b0, 32'h0);
    req(3'd4, 4'd2, 4'd5, BASE + 32'hFFC, 4'hF, 32'h0, 1'b0);
    expect_d("last_get", 3'd1, 4'd5, 4'd2, 1'b0, 1'b0, 32'h1234_5678);

    for (int i = 0; i < 8; i++)
      req(3'd0, 4'd2, 4'd0, BASE + 32'h100 + 32'(4 * i), 4'hF, 32'hA000_0000 + 32'(i), 1'b0);
    idle_cycle();
    chk("drain.valid", 64'(d_valid), 64'(0));

    issued = 0;
    got    = 0;
    for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
      d_ready = pat[cyc % 4];
      if (issued < 8) begin
        a_valid   = 1'b1;
        a_opcode  = 3'd4;
        a_size    = 4'd2;
        a_source  = 4'(issued + 4);
        a_address = BASE + 32'h100 + 32'(4 * issued);
        a_mask    = 4'hF;
        a_data    = 32'h0;
      end else begin
        a_valid = 1'b0;
      end
      #1;
      exp_rdy = (qsrc.size() == 0) || d_ready;
      chk("bp.aready", 64'(a_ready), 64'(exp_rdy));
      chk("bp.valid", 64'(d_valid), 64'(qsrc.size() != 0));
      if (qsrc.size() != 0) begin
        chk("bp.src", 64'(d_source), 64'(qsrc[0]));
        chk("bp.data", 64'(d_data), 64'(qdat[0]));
      end
      fire_a = a_valid && exp_rdy;
      fire_d = (qsrc.size() != 0) && d_ready;
      @(posedge tilelink_clock);
      #1;
      if (fire_d) begin
        void'(qsrc.pop_front());
        void'(qdat.pop_front());
        got++;
      end
      if (fire_a) begin
        qsrc.push_back(4'(issued + 4));
        qdat.push_back(32'hA000_0000 + 32'(issued));
        issued++;
      end
    end
    a_valid = 1'b0;
    if (got < 8) chk("bp.timeout", 64'(got), 64'(8));
    d_ready = 1'b1;
    idle_cycle();

    d_ready = 1'b0;
    req(3'd4, 4'd2, 4'd9, BASE + 32'h10, 4'hF, 32'h0, 1'b0);
    chk("mid.valid", 64'(d_valid), 64'(1));
    chk("mid.aready", 64'(a_ready), 64'(0));
    #3;
    tilelink_reset = 1'b0;
    #1;
    chk("mid.rst_valid", 64'(d_valid), 64'(0));
    chk("mid.rst_src", 64'(d_source), 64'(0));
    chk("mid.rst_data", 64'(d_data), 64'(0));
    #1;
    tilelink_reset = 1'b1;
    #1;
    chk("mid.aready_after", 64'(a_ready), 64'(1));
    d_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      chk("mid.no_stale", 64'(d_valid), 64'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
